// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register file sizing and dump reader state encoding
package rf_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register address range and streams address/data beats
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, abort          begin a dump (IDLE only) / cancel a dump in READ or SEND
//   start_addr, end_addr  inclusive register range, latched when start is accepted
//   busy, done            dump in progress / one-cycle pulse after the final beat
//   rf_read_enable/addr   register file read port request (active only in READ)
//   rf_read_data          combinational register file read data
//   m_valid, m_ready      output beat handshake
//   m_addr, m_data, m_last  beat payload, held stable until accepted
module regfile_dump_reader #(
    parameter int NUM_REGS = rf_pkg::RF_NUM_REGS,
    parameter int ADDR_W   = rf_pkg::RF_ADDR_W,
    parameter int DATA_W   = rf_pkg::RF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic              rf_read_enable,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    import rf_pkg::*;

    dump_state_t       state;
    dump_state_t       next_state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] stop;
    logic [ADDR_W-1:0] cur_inc;
    logic              start_go;
    logic              read_go;
    logic              advance;

    // abort has priority over every other event in IDLE, READ and SEND
    assign start_go = (state == IDLE) && start && !abort;
    assign read_go  = (state == READ) && !abort;
    assign advance  = (state == SEND) && !abort && m_ready && !m_last;

    // Walk wraps from NUM_REGS-1 back to 0 so end_addr < start_addr dumps across the top
    assign cur_inc = ADDR_W'((32'(cur) + 32'd1) % 32'(NUM_REGS));

    // Read port is driven only in READ; address parks at 0 otherwise
    assign rf_read_enable = (state == READ);
    assign rf_read_addr   = rf_read_enable ? cur : '0;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_go) begin
                    next_state = READ;
                end
            end
            READ: begin
                next_state = abort ? IDLE : SEND;
            end
            SEND: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (m_ready) begin
                    next_state = m_last ? DONE : READ;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs are registered from next_state so they line up with the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            cur     <= '0;
            stop    <= '0;
        end else begin
            state   <= next_state;
            busy    <= (next_state == READ) || (next_state == SEND);
            done    <= (next_state == DONE);
            m_valid <= (next_state == SEND);
            if (start_go) begin
                cur  <= start_addr;
                stop <= end_addr;
            end
            if (read_go) begin
                m_data <= rf_read_data;
                m_addr <= cur;
                m_last <= (cur == stop);
            end
            if (advance) begin
                cur <= cur_inc;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed table-driven bench for regfile_dump_reader
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  start_addr;
    logic [4:0]  end_addr;
    logic        busy;
    logic        done;
    logic        rf_read_enable;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_last;

    logic [31:0] regs [32];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0] sa;
        logic [4:0] ea;
        bit         toggle;
        int         beats;
        int         done_cyc;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    // Poison value outside READ so a sample at the wrong time shows up as bad data
    assign rf_read_data = rf_read_enable ? regs[rf_read_addr] : 32'hDEAD_BEEF;

    regfile_dump_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .start_addr     (start_addr),
        .end_addr       (end_addr),
        .busy           (busy),
        .done           (done),
        .rf_read_enable (rf_read_enable),
        .rf_read_addr   (rf_read_addr),
        .rf_read_data   (rf_read_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_addr         (m_addr),
        .m_data         (m_data),
        .m_last         (m_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),           32'd0);
        chk({tag, "_done"},   32'(done),           32'd0);
        chk({tag, "_rden"},   32'(rf_read_enable), 32'd0);
        chk({tag, "_raddr"},  32'(rf_read_addr),   32'd0);
        chk({tag, "_valid"},  32'(m_valid),        32'd0);
        chk({tag, "_last"},   32'(m_last),         32'd0);
        chk({tag, "_maddr"},  32'(m_addr),         32'd0);
        chk({tag, "_mdata"},  m_data,              32'd0);
    endtask

    // Issues start in the current cycle and follows the dump cycle by cycle.
    // exp_rd / exp_vld track which cycles must be READ / SEND from the bench's own view.
    task automatic run_dump(input logic [4:0] sa, input logic [4:0] ea, input bit toggle,
                            input int exp_beats, input int exp_done);
        int         beats = 0;
        bit         exp_rd = 1'b1;
        bit         exp_vld = 1'b0;
        bit         tog = 1'b0;
        bit         got_done = 1'b0;
        bit         is_last;
        bit         hs;
        logic [4:0] a;
        start_addr = sa;
        end_addr   = ea;
        abort      = 1'b0;
        m_ready    = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 200 && !got_done; c++) begin
            a       = sa + 5'(beats);
            is_last = (beats == exp_beats - 1);
            chk("rd_enable", 32'(rf_read_enable), 32'(exp_rd));
            chk("busy", 32'(busy), 32'(exp_rd | exp_vld));
            if (exp_rd) begin
                chk("rd_addr", 32'(rf_read_addr), 32'(a));
            end
            chk("m_valid", 32'(m_valid), 32'(exp_vld));
            if (exp_vld) begin
                chk("m_addr", 32'(m_addr), 32'(a));
                chk("m_data", m_data, regs[a]);
                chk("m_last", 32'(m_last), 32'(is_last));
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_cycle", 32'(c), 32'(exp_done));
                chk("beat_count", 32'(beats), 32'(exp_beats));
            end
            if (toggle) begin
                m_ready = exp_vld ? tog : 1'b1;
                if (exp_vld) begin
                    tog = ~tog;
                end
            end
            hs      = exp_vld && m_ready;
            exp_vld = exp_rd || (exp_vld && !m_ready);
            exp_rd  = hs && !is_last;
            if (hs) begin
                beats++;
            end
            if (!got_done) begin
                @(posedge clk); #1;
            end
        end
        if (!got_done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'(i) * 32'h1111;
        end
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = 5'd0;
        end_addr   = 5'd0;
        m_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // start together with abort in IDLE must be dropped
        start_addr = 5'd3;
        end_addr   = 5'd9;
        start      = 1'b1;
        abort      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_wins_busy", 32'(busy), 32'd0);
        chk("abort_wins_rden", 32'(rf_read_enable), 32'd0);
        @(posedge clk); #1;

        vecs[0] = '{5'd0,  5'd31, 1'b0, 32, 65};
        vecs[1] = '{5'd30, 5'd1,  1'b0, 4,  9};
        vecs[2] = '{5'd7,  5'd7,  1'b0, 1,  3};
        vecs[3] = '{5'd10, 5'd14, 1'b1, 5,  16};
        vecs[4] = '{5'd31, 5'd30, 1'b0, 32, 65};
        for (int v = 0; v < 5; v++) begin
            run_dump(vecs[v].sa, vecs[v].ea, vecs[v].toggle, vecs[v].beats, vecs[v].done_cyc);
        end

        // abort while the third beat (address 6) is waiting in SEND
        start_addr = 5'd4;
        end_addr   = 5'd12;
        m_ready    = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_pre_valid", 32'(m_valid), 32'd1);
        chk("abort_pre_addr", 32'(m_addr), 32'd6);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", 32'(m_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("abort_done2", 32'(done), 32'd0);
        run_dump(5'd20, 5'd21, 1'b0, 2, 5);

        // start while busy is ignored; reset mid-READ clears everything at once
        start_addr = 5'd0;
        end_addr   = 5'd31;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_seq_rden1", 32'(rf_read_enable), 32'd1);
        chk("rst_seq_addr1", 32'(rf_read_addr), 32'd0);
        @(posedge clk); #1;
        chk("rst_seq_send_rden", 32'(rf_read_enable), 32'd0);
        start_addr = 5'd17;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start_ignored", 32'(rf_read_addr), 32'd1);
        chk("rst_seq_rden2", 32'(rf_read_enable), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        run_dump(5'd3, 5'd3, 1'b0, 1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
